// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory slave with programmable wait states,
// byte-lane writes and registered ack/err/rdata responses.
module dmem_responder #(
  parameter int DEPTH = 1024,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d, be_q, be_d, t_be;
  logic        we_q, we_d, t_we, ack_q, ack_d, err_q, err_d, busy_q, busy_d;
  logic        take, go, bad, mem_we;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, t_addr, t_wdata;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];
  // In IDLE the live request is used so WAIT=0 can respond on the accept edge itself.
  always_comb begin
    take    = state_q == S_IDLE && req;
    t_addr  = state_q == S_IDLE ? addr  : addr_q;
    t_wdata = state_q == S_IDLE ? wdata : wdata_q;
    t_we    = state_q == S_IDLE ? we    : we_q;
    t_be    = state_q == S_IDLE ? be    : be_q;
    idx     = t_addr[AW+1:2];
    bad     = |t_addr[1:0] || {2'b0, t_addr[31:2]} >= 32'(DEPTH);
    go      = (take && WAIT == 0) || (state_q == S_WAIT && cnt_q == 4'd0);
    mem_we  = go && !bad && t_we && !reset;
    state_d = go ? S_RESP : take ? S_WAIT : state_q == S_WAIT ? S_WAIT : S_IDLE;
    cnt_d   = take && WAIT != 0 ? 4'(WAIT - 1) : state_q == S_WAIT && cnt_q != 4'd0 ? cnt_q - 4'd1 : 4'd0;
    addr_d  = take ? addr  : addr_q;
    wdata_d = take ? wdata : wdata_q;
    we_d    = take ? we    : we_q;
    be_d    = take ? be    : be_q;
    ack_d   = go;
    err_d   = go && bad;
    rdata_d = go && !bad && !t_we ? mem[idx] : 32'd0;
    busy_d  = state_d != S_IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      be_q    <= be_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we && t_be[i]) mem[idx][8*i +: 8] <= t_wdata[8*i +: 8];
  end
  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a WAIT=2 and a WAIT=0 instance.
module tb_dmem_responder;
  logic        clk = 1'b0, reset = 1'b0;
  logic        req_a [2], we_a [2], ack_a [2], err_a [2], busy_a [2];
  logic [31:0] addr_a [2], wdata_a [2], rdata_a [2];
  logic [3:0]  be_a [2];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH(1024), .WAIT(2)) u_w2 (
    .clk(clk), .reset(reset), .req(req_a[0]), .we(we_a[0]), .addr(addr_a[0]),
    .wdata(wdata_a[0]), .be(be_a[0]), .rdata(rdata_a[0]), .ack(ack_a[0]),
    .err(err_a[0]), .busy(busy_a[0]));
  dmem_responder #(.DEPTH(16), .WAIT(0)) u_w0 (
    .clk(clk), .reset(reset), .req(req_a[1]), .we(we_a[1]), .addr(addr_a[1]),
    .wdata(wdata_a[1]), .be(be_a[1]), .rdata(rdata_a[1]), .ack(ack_a[1]),
    .err(err_a[1]), .busy(busy_a[1]));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic txn(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] er, input logic ee,
                     input int wt, input string tag);
    int n;
    req_a[i] = 1'b1; we_a[i] = w; addr_a[i] = a; wdata_a[i] = d; be_a[i] = b;
    step();
    req_a[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = 32'hFFFF_FFFF; wdata_a[i] = 32'h0; be_a[i] = 4'h0;
    chk({tag, " busy"}, 32'(busy_a[i]), 32'd1);
    n = 0;
    while (!ack_a[i] && n < 20) begin
      step();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(wt));
    chk({tag, " ack"}, 32'(ack_a[i]), 32'd1);
    chk({tag, " err"}, 32'(err_a[i]), 32'(ee));
    if (!w) chk({tag, " rdata"}, rdata_a[i], er);
    step();
    chk({tag, " ack drop"}, 32'(ack_a[i]), 32'd0);
    chk({tag, " rdata idle"}, rdata_a[i], 32'd0);
    chk({tag, " err idle"}, 32'(err_a[i]), 32'd0);
  endtask
  initial begin
    logic [15:0] ack_m, bl_m;
    for (int i = 0; i < 2; i++) begin
      req_a[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = 32'd0; wdata_a[i] = 32'd0; be_a[i] = 4'd0;
    end
    reset = 1'b1;
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      chk("rst ack", 32'(ack_a[i]), 32'd0);
      chk("rst err", 32'(err_a[i]), 32'd0);
      chk("rst busy", 32'(busy_a[i]), 32'd0);
      chk("rst rdata", rdata_a[i], 32'd0);
    end
    reset = 1'b0;
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 2, "wr10");
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 2, "rd10");
    txn(0, 1'b1, 32'h10, 32'h0000_0055, 4'b0001, 32'h0, 1'b0, 2, "wr10b0");
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BE55, 1'b0, 2, "rd10b0");
    txn(0, 1'b0, 32'h12, 32'h0, 4'hF, 32'h0, 1'b1, 2, "rd misalign");
    txn(0, 1'b0, 32'h1000, 32'h0, 4'hF, 32'h0, 1'b1, 2, "rd range");
    txn(0, 1'b1, 32'h1010, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 2, "wr range");
    txn(0, 1'b1, 32'h11, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 2, "wr misalign");
    txn(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 2, "wr be0");
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BE55, 1'b0, 2, "rd unchanged");
    req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 32'h10;
    ack_m = 16'h0; bl_m = 16'h0;
    for (int c = 1; c <= 12; c++) begin
      step();
      ack_m[c] = ack_a[0];
      bl_m[c] = !busy_a[0];
      if (ack_a[0]) chk("b2b rdata", rdata_a[0], 32'hDEAD_BE55);
    end
    req_a[0] = 1'b0;
    chk("b2b ack pos", 32'(ack_m), 32'h0888);
    chk("b2b busy low", 32'(bl_m), 32'h1110);
    step();
    txn(0, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 2, "wr20");
    req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 32'h20; wdata_a[0] = 32'hFFFF_FFFF; be_a[0] = 4'hF;
    step();
    req_a[0] = 1'b0; we_a[0] = 1'b0;
    chk("abort busy pre", 32'(busy_a[0]), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", 32'(busy_a[0]), 32'd0);
    chk("abort ack", 32'(ack_a[0]), 32'd0);
    step();
    chk("abort ack2", 32'(ack_a[0]), 32'd0);
    reset = 1'b0;
    txn(0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 2, "rd20 after rst");
    txn(1, 1'b1, 32'h8, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0, 0, "w0 wr8");
    txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0, 0, "w0 rd8");
    txn(1, 1'b1, 32'h8, 32'h0000_3C00, 4'b0010, 32'h0, 1'b0, 0, "w0 wr8b1");
    txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 32'hA5A5_3CA5, 1'b0, 0, "w0 rd8b1");
    txn(1, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b1, 0, "w0 range");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words stored (power of 2).
REQ-002 SHALL have parameter WAIT, default 2, meaning wait-state cycles inserted before each ack (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  1  initiator access request, held high until ack.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; qualified by req.
REQ-007 SHALL have port addr  input  32  byte address.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port be  input  4  byte-lane write enables; be[i] controls wdata[8i+7:8i].
REQ-010 SHALL have port rdata  output  32  read data; valid only while ack=1.
REQ-011 SHALL have port ack  output  1  one-cycle transaction-complete pulse.
REQ-012 SHALL have port err  output  1  error flag; valid only while ack=1.
REQ-013 SHALL have port busy  output  1  high whenever a transaction is in progress (state != IDLE).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; outputs registered.
REQ-015 SHALL in IDLE, on an edge with req=1, latch addr, we, wdata, be; go to RESP if WAIT=0, else go to WAIT with counter = WAIT-1.
REQ-016 SHALL in WAIT, go to RESP when counter = 0; otherwise decrement counter (4-bit counter).
REQ-017 SHALL in RESP, drive ack=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-018 SHALL give latency: ack high during the cycle following edge (accept edge + WAIT); WAIT=0 gives ack in the cycle directly after the accept edge.
REQ-019 SHALL ignore req while busy=1; req dropped mid-transaction does not abort it (transaction completes with ack).
REQ-020 SHALL not accept req during the RESP cycle; the minimum spacing between accept edges is WAIT+2 cycles.
REQ-021 SHALL flag an error when latched addr[1:0] != 0 or word index addr[31:2] >= DEPTH.
REQ-022 SHALL on error: perform no memory access, assert ack with err=1 and rdata=0.
REQ-023 SHALL commit a valid write on the edge entering RESP, updating only lanes with be[i]=1; be=4'b0000 is acked with no state change.
REQ-024 SHALL on a valid read, return the full word at addr[31:2] with err=0, ignoring be; the read value reflects all writes acked earlier.
REQ-025 SHALL hold rdata=0 and err=0 whenever ack=0.

Reset
REQ-026 SHALL, on reset high, immediately force state IDLE, counter 0, ack=0, err=0, rdata=0, busy=0.
REQ-027 SHALL, on reset asserted before the edge entering RESP, commit no pending write and issue no ack.
REQ-028 SHALL leave memory contents unchanged by reset (not cleared).
REQ-029 SHALL accept a new request on the first rising edge after reset deasserts.

Verification
REQ-030 SHALL pass: WAIT=2, write addr=0x10, wdata=0xDEADBEEF, be=4'hF, then read 0x10 -> ack exactly 2 cycles after each accept edge, rdata=0xDEADBEEF, err=0.
REQ-031 SHALL pass: after the previous case, write 0x10 with wdata=0x00000055, be=4'b0001, then read -> rdata=0xDEADBE55.
REQ-032 SHALL pass: read addr=0x12 (misaligned) and addr=DEPTH*4 -> ack with err=1, rdata=0, memory unchanged.
REQ-033 SHALL pass: req held high continuously for 3 transactions -> accept edges spaced WAIT+2 cycles, one ack per transaction, busy low only for the accept cycle.
REQ-034 SHALL pass: write 0x20=0x12345678, then write 0x20=0xFFFFFFFF with reset pulsed during WAIT, then read 0x20 -> no ack for the aborted write, rdata=0x12345678.
REQ-035 SHALL pass: WAIT=0, read -> ack in the cycle right after the accept edge; req dropped after acceptance still yields one ack.
